// File: rtl/nios2_debug_mon_access_ctrl.sv
// Debug monitor access controller: turns JTAG command strobes into single-word
// Avalon-MM accesses on the debug memory, with address auto-increment and a stall timeout.
module nios2_debug_mon_access_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_err,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [15:0]       TO_LAST  = 16'(TIMEOUT_CYC - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] mon_a_reg;
  logic [15:0]       to_cnt;
  logic              strobe_any;
  logic              timeout;
  logic              unused_jdo;

  assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign timeout    = avm_waitrequest && (to_cnt == TO_LAST);
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (take_action_ocimem_a) state_next = jdo[34] ? RD : IDLE;
        else if (take_action_ocimem_b) state_next = WR;
        else if (take_no_action_ocimem_a) state_next = RD;
      end
      RD, WR: begin
        if (!avm_waitrequest || timeout) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    avm_read      = (state == RD);
    avm_write     = (state == WR);
    monitor_ready = (state == IDLE);
    avm_address   = mon_a_reg;
  end

  // A strobe arriving mid-access is an overrun: flag it but leave the access alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_a_reg     <= '0;
      MonDReg       <= '0;
      avm_writedata <= '0;
      to_cnt        <= '0;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (take_action_ocimem_a) begin
            mon_a_reg <= jdo[ADDR_W+25:26];
            if (jdo[25]) monitor_error <= 1'b0;
          end else if (take_action_ocimem_b) begin
            MonDReg       <= jdo[34:3];
            avm_writedata <= jdo[34:3];
          end
        end
        default: begin
          if (strobe_any) monitor_error <= 1'b1;
          if (!avm_waitrequest) begin
            if (state == RD) MonDReg <= avm_readdata;
            mon_a_reg <= mon_a_reg + ADDR_ONE;
            if (avm_err) monitor_error <= 1'b1;
          end else if (timeout) begin
            monitor_error <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_debug_mon_access_ctrl.sv
// Bench for nios2_debug_mon_access_ctrl: table of commands driven through a small
// Avalon slave responder, expected results queued at drive time and checked at completion.
module tb_nios2_debug_mon_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic [7:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;
  logic        avm_err = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        sa;
    logic        sb;
    logic        sn;
    logic [37:0] jdo;
    int          ws;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  exp_rw;
    logic [7:0]  exp_req_addr;
    int          exp_cycles;
    logic [31:0] exp_dreg;
    logic [7:0]  exp_addr;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          cycles;
    logic [31:0] dreg;
    logic [7:0]  addr;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[9];
  vec_t ov;

  nios2_debug_mon_access_ctrl #(.ADDR_W(8), .TIMEOUT_CYC(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_write(avm_write),
    .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .avm_err(avm_err),
    .MonDReg(MonDReg),
    .monitor_ready(monitor_ready),
    .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] mk_a(input logic [7:0] addr, input logic rd, input logic clr);
    return {3'b000, rd, addr, clr, 25'd0};
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] data);
    return {3'b000, data, 3'b000};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Strobe one command, answer the bus as a slave with ws wait states (ws<0: stall forever),
  // optionally pulse a no_action strobe at request cycle ov_at, then score the result.
  task automatic apply_stimulus(input vec_t v, input int ov_at);
    int   cyc;
    exp_t e;
    @(negedge clk);
    take_action_ocimem_a    = v.sa;
    take_action_ocimem_b    = v.sb;
    take_no_action_ocimem_a = v.sn;
    jdo                     = v.jdo;
    sb_q.push_back('{v.exp_cycles, v.exp_dreg, v.exp_addr, v.exp_err});
    @(negedge clk);
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    cyc = 0;
    while ((avm_read || avm_write) && cyc < 20) begin
      check_output("req_kind", {30'd0, avm_read, avm_write}, {30'd0, v.exp_rw});
      check_output("req_addr", {24'd0, avm_address}, {24'd0, v.exp_req_addr});
      if (v.exp_rw == 2'b01) check_output("req_wdata", avm_writedata, v.jdo[34:3]);
      avm_waitrequest         = (v.ws < 0) || (cyc < v.ws);
      avm_readdata            = v.rdata;
      avm_err                 = v.err;
      take_no_action_ocimem_a = (cyc == ov_at);
      cyc++;
      @(negedge clk);
      take_no_action_ocimem_a = 1'b0;
    end
    avm_waitrequest = 1'b0;
    avm_err         = 1'b0;
    e = sb_q.pop_front();
    check_output("req_cycles", cyc, e.cycles);
    check_output("ready_after", {31'd0, monitor_ready}, 32'd1);
    check_output("MonDReg", MonDReg, e.dreg);
    check_output("MonAReg", {24'd0, avm_address}, {24'd0, e.addr});
    check_output("monitor_error", {31'd0, monitor_error}, {31'd0, e.err});
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, mk_a(8'h10, 1'b1, 1'b0), 0, 32'hDEADBEEF, 1'b0,
               2'b10, 8'h10, 1, 32'hDEADBEEF, 8'h11, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, mk_a(8'hFF, 1'b0, 1'b0), 0, 32'h0, 1'b0,
               2'b00, 8'h00, 0, 32'hDEADBEEF, 8'hFF, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, mk_b(32'h12345678), 3, 32'h0, 1'b0,
               2'b01, 8'hFF, 4, 32'h12345678, 8'h00, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 38'd0, 1, 32'hA5A50001, 1'b1,
               2'b10, 8'h00, 2, 32'hA5A50001, 8'h01, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, mk_a(8'h20, 1'b1, 1'b1), 2, 32'h0000CAFE, 1'b0,
               2'b10, 8'h20, 3, 32'h0000CAFE, 8'h21, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 38'd0, -1, 32'hBAD0BAD0, 1'b0,
               2'b10, 8'h21, 4, 32'h0000CAFE, 8'h21, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, mk_a(8'h30, 1'b0, 1'b1), 0, 32'h0, 1'b0,
               2'b00, 8'h00, 0, 32'h0000CAFE, 8'h30, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, mk_a(8'h40, 1'b0, 1'b0), 0, 32'h0, 1'b0,
               2'b00, 8'h00, 0, 32'h0000CAFE, 8'h40, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, mk_b(32'h0BADF00D), 0, 32'h0, 1'b0,
               2'b01, 8'h40, 1, 32'h0BADF00D, 8'h41, 1'b0};
    ov     = '{1'b0, 1'b1, 1'b0, mk_b(32'h55AA55AA), 3, 32'h0, 1'b0,
               2'b01, 8'h41, 4, 32'h55AA55AA, 8'h42, 1'b1};

    $display("[TB] reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_output("rst_read", {31'd0, avm_read}, 32'd0);
    check_output("rst_write", {31'd0, avm_write}, 32'd0);
    check_output("rst_wdata", avm_writedata, 32'd0);
    check_output("rst_addr", {24'd0, avm_address}, 32'd0);
    check_output("rst_MonDReg", MonDReg, 32'd0);
    check_output("rst_ready", {31'd0, monitor_ready}, 32'd1);
    check_output("rst_error", {31'd0, monitor_error}, 32'd0);

    $display("[TB] command table");
    for (int i = 0; i < 9; i++) apply_stimulus(tbl[i], -1);

    $display("[TB] overrun during stalled write");
    apply_stimulus(ov, 1);

    $display("[TB] reset during stalled read");
    @(negedge clk);
    take_action_ocimem_a = 1'b1;
    jdo = mk_a(8'h50, 1'b1, 1'b1);
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
    avm_waitrequest = 1'b1;
    avm_readdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    check_output("mid_read", {31'd0, avm_read}, 32'd1);
    check_output("mid_ready", {31'd0, monitor_ready}, 32'd0);
    check_output("mid_error", {31'd0, monitor_error}, 32'd0);
    check_output("mid_addr", {24'd0, avm_address}, 32'h50);
    check_output("mid_MonDReg", MonDReg, 32'h55AA55AA);
    #2 reset_n = 1'b0;
    #1;
    check_output("arst_read", {31'd0, avm_read}, 32'd0);
    check_output("arst_write", {31'd0, avm_write}, 32'd0);
    check_output("arst_MonDReg", MonDReg, 32'd0);
    check_output("arst_addr", {24'd0, avm_address}, 32'd0);
    check_output("arst_ready", {31'd0, monitor_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    avm_waitrequest = 1'b0;
    @(negedge clk);
    check_output("post_rst_read", {31'd0, avm_read}, 32'd0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
